// File: rtl/j1_timer_pkg.sv
// Shared register map, CTRL field layout and prescaler helper for the j1 timer bank.
// Imported by the channel and the bank top.
package j1_timer_pkg;

   typedef enum logic [1:0] {
      REG_COUNT  = 2'd0,
      REG_RELOAD = 2'd1,
      REG_CTRL   = 2'd2,
      REG_STATUS = 2'd3
   } reg_e;

   localparam int CTRL_EN     = 0;
   localparam int CTRL_AUTO   = 1;
   localparam int CTRL_IE     = 2;
   localparam int CTRL_PS_LSB = 4;
   localparam int CTRL_PS_W   = 4;
   localparam int CTRL_W      = 8;

   // Bit 3 is unimplemented and always reads 0.
   localparam logic [CTRL_W-1:0] CTRL_MASK = 8'hF7;

   localparam int PRE_W = 15;

   // True when the low ps bits of the shared prescaler are all ones (always true for ps=0).
   function automatic logic ps_match(input logic [PRE_W-1:0] pre,
                                     input logic [CTRL_PS_W-1:0] ps);
      logic [PRE_W-1:0] mask;
      for (int b = 0; b < PRE_W; b++) begin
         mask[b] = (b < int'(ps));
      end
      return (pre & mask) == mask;
   endfunction

endpackage

// File: rtl/j1_timer_channel.sv
// One timer channel: COUNT, RELOAD, CTRL and the sticky pending flag.
// The tick input already includes EN and the prescaler match.
module j1_timer_channel
   import j1_timer_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic              clk,
   input  logic              resetq,
   input  logic              tick,
   input  logic              wr_count,
   input  logic              wr_reload,
   input  logic              wr_ctrl,
   input  logic              wr_status,
   input  logic [WIDTH-1:0]  wdata,
   output logic [WIDTH-1:0]  count,
   output logic [WIDTH-1:0]  reload,
   output logic [CTRL_W-1:0] ctrl,
   output logic              pending
);

   logic [WIDTH-1:0]  count_q, count_d;
   logic [WIDTH-1:0]  reload_q, reload_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic              pending_q, pending_d;
   logic              overflow;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      count_d   = count_q;
      reload_d  = reload_q;
      ctrl_d    = ctrl_q;
      overflow  = 1'b0;

      // A CPU write to COUNT beats a coincident tick; RELOAD is read before any same-cycle write lands.
      if (wr_count) begin
         count_d = wdata;
      end else if (tick) begin
         if (count_q != '1) begin
            count_d = count_q + WIDTH'(1);
         end else begin
            overflow = 1'b1;
            count_d  = ctrl_q[CTRL_AUTO] ? reload_q : '0;
         end
      end

      if (wr_reload) reload_d = wdata;
      if (wr_ctrl)   ctrl_d   = wdata[CTRL_W-1:0] & CTRL_MASK;

      // Set dominates a simultaneous write-1-to-clear.
      pending_d = overflow | (pending_q & ~(wr_status & wdata[0]));
   end

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         count_q   <= '0;
         reload_q  <= '0;
         ctrl_q    <= '0;
         pending_q <= 1'b0;
      end else begin
         // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
         count_q   <= count_d;
         reload_q  <= reload_d;
         ctrl_q    <= ctrl_d;
         pending_q <= pending_d;
      end
   end

   assign count   = count_q;
   assign reload  = reload_q;
   assign ctrl    = ctrl_q;
   assign pending = pending_q;

endmodule

// File: rtl/j1_timer_bank.sv
// Multi-channel timer peripheral on the j1 IO bus: shared prescaler, address decode,
// combinational read mux and registered interrupt outputs.
module j1_timer_bank
   import j1_timer_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int NCH     = 4,
   parameter int SEL_BIT = 14,
   parameter int CH_LSB  = 2
) (
   input  logic             clk,
   input  logic             resetq,
   input  logic             io_rd,
   input  logic             io_wr,
   input  logic [15:0]      io_addr,
   input  logic [WIDTH-1:0] io_dout,
   output logic [WIDTH-1:0] io_din,
   output logic             irq,
   output logic [NCH-1:0]   irq_vec
);

   logic             sel;
   logic [3:0]       ch;
   reg_e             reg_sel;
   logic [PRE_W-1:0] pre_q, pre_d;

   logic [WIDTH-1:0]  count_a  [NCH];
   logic [WIDTH-1:0]  reload_a [NCH];
   logic [CTRL_W-1:0] ctrl_a   [NCH];
   logic [NCH-1:0]    pending;
   logic [NCH-1:0]    tick;
   logic [NCH-1:0]    ie;

   logic [NCH-1:0] irq_vec_q, irq_vec_d;
   logic           irq_q, irq_d;

   // Reads have no side effects, so the read strobe and unused address bits are not needed.
   logic unused_bus;
   assign unused_bus = ^{io_rd, io_addr};

   assign sel     = io_addr[SEL_BIT];
   assign ch      = io_addr[CH_LSB+3:CH_LSB];
   assign reg_sel = reg_e'(io_addr[1:0]);

   assign pre_d = pre_q + PRE_W'(1);

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic hit;
      // Channel indices at or above NCH match no instance, so those writes fall away.
      assign hit     = io_wr & sel & (ch == 4'(i));
      assign tick[i] = ctrl_a[i][CTRL_EN] & ps_match(pre_q, ctrl_a[i][CTRL_PS_LSB +: CTRL_PS_W]);
      assign ie[i]   = ctrl_a[i][CTRL_IE];

      j1_timer_channel #(
         .WIDTH(WIDTH)
      ) u_ch (
         .clk       (clk),
         .resetq    (resetq),
         .tick      (tick[i]),
         .wr_count  (hit & (reg_sel == REG_COUNT)),
         .wr_reload (hit & (reg_sel == REG_RELOAD)),
         .wr_ctrl   (hit & (reg_sel == REG_CTRL)),
         .wr_status (hit & (reg_sel == REG_STATUS)),
         .wdata     (io_dout),
         .count     (count_a[i]),
         .reload    (reload_a[i]),
         .ctrl      (ctrl_a[i]),
         .pending   (pending[i])
      );
   end

   always_comb begin
      io_din = '0;
      for (int i = 0; i < NCH; i++) begin
         if (sel && ch == 4'(i)) begin
            case (reg_sel)
               REG_COUNT:  io_din = count_a[i];
               REG_RELOAD: io_din = reload_a[i];
               REG_CTRL:   io_din = WIDTH'(ctrl_a[i]);
               REG_STATUS: io_din = WIDTH'(pending[i]);
            endcase
         end
      end
   end

   always_comb begin
      irq_vec_d = pending & ie;
      irq_d     = |irq_vec_d;
   end

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         pre_q     <= '0;
         irq_vec_q <= '0;
         irq_q     <= 1'b0;
      end else begin
         pre_q     <= pre_d;
         irq_vec_q <= irq_vec_d;
         irq_q     <= irq_d;
      end
   end

   assign irq     = irq_q;
   assign irq_vec = irq_vec_q;

endmodule

// File: tb/tb_j1_timer_bank.sv
// Directed self-checking bench for j1_timer_bank (NCH=4, WIDTH=16).
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_j1_timer_bank;

   logic        clk;
   logic        resetq;
   logic        io_rd;
   logic        io_wr;
   logic [15:0] io_addr;
   logic [15:0] io_dout;
   logic [15:0] io_din;
   logic        irq;
   logic [3:0]  irq_vec;

   int checks = 0;
   int errors = 0;

   j1_timer_bank dut (
      .clk     (clk),
      .resetq  (resetq),
      .io_rd   (io_rd),
      .io_wr   (io_wr),
      .io_addr (io_addr),
      .io_dout (io_dout),
      .io_din  (io_din),
      .irq     (irq),
      .irq_vec (irq_vec)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [15:0] a(input int chn, input int r);
      return 16'h4000 | 16'(chn << 2) | 16'(r);
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [15:0] addr, input logic [15:0] d);
      io_addr = addr;
      io_dout = d;
      io_wr   = 1'b1;
      step(1);
      io_wr   = 1'b0;
   endtask

   task automatic chk_rd(input string tag, input logic [15:0] addr, input logic [15:0] exp);
      io_addr = addr;
      io_rd   = 1'b1;
      #1;
      chk(tag, io_din, exp);
      io_rd   = 1'b0;
   endtask

   initial begin
      logic        found;
      logic [15:0] v;

      resetq  = 1'b1;
      io_rd   = 1'b0;
      io_wr   = 1'b0;
      io_addr = '0;
      io_dout = '0;

      // Reset state.
      #2 resetq = 1'b0;
      #1;
      chk("rst_irq", {15'b0, irq}, 16'h0000);
      chk("rst_irq_vec", {12'b0, irq_vec}, 16'h0000);
      step(2);
      chk_rd("rst_ch0_count", a(0, 0), 16'h0000);
      chk_rd("rst_ch2_ctrl", a(2, 2), 16'h0000);
      @(negedge clk) resetq = 1'b1;
      step(1);

      // Ch0 auto-reload with IE at PS=0.
      wr(a(0, 1), 16'hFFF0);
      wr(a(0, 0), 16'hFFFE);
      wr(a(0, 2), 16'h0007);
      chk_rd("ch0_after_en", a(0, 0), 16'hFFFE);
      step(1);
      chk_rd("ch0_ffff", a(0, 0), 16'hFFFF);
      step(1);
      chk_rd("ch0_reload", a(0, 0), 16'hFFF0);
      chk_rd("ch0_pending", a(0, 3), 16'h0001);
      chk("ch0_irq_lat0", {15'b0, irq}, 16'h0000);
      step(1);
      chk("ch0_irq", {15'b0, irq}, 16'h0001);
      chk("ch0_irq_vec", {12'b0, irq_vec}, 16'h0001);
      step(14);
      chk_rd("ch0_pre_ovf2", a(0, 0), 16'hFFFF);
      step(1);
      chk_rd("ch0_ovf2", a(0, 0), 16'hFFF0);
      wr(a(0, 2), 16'h0006);
      wr(a(0, 3), 16'h0001);
      chk("ch0_clr_irq_hold", {15'b0, irq}, 16'h0001);
      step(1);
      chk("ch0_clr_irq", {15'b0, irq}, 16'h0000);

      // Ch1 PS=3, wrap to zero, no IE.
      wr(a(1, 0), 16'hFFFE);
      wr(a(1, 2), 16'h0031);
      found = 1'b0;
      for (int k = 0; k < 16 && !found; k++) begin
         step(1);
         io_addr = a(1, 0);
         #1 v = io_din;
         if (v == 16'hFFFF) found = 1'b1;
      end
      chk("ch1_first_tick", {15'b0, found}, 16'h0001);
      step(7);
      chk_rd("ch1_hold_8", a(1, 0), 16'hFFFF);
      step(1);
      chk_rd("ch1_wrap", a(1, 0), 16'h0000);
      chk_rd("ch1_pending", a(1, 3), 16'h0001);
      step(1);
      chk("ch1_no_irq", {15'b0, irq}, 16'h0000);
      wr(a(1, 2), 16'h0000);

      // Ch2 overflow coincides with a STATUS clear: set wins.
      wr(a(2, 0), 16'hFFFF);
      wr(a(2, 2), 16'h0005);
      wr(a(2, 3), 16'h0001);
      chk_rd("ch2_set_wins", a(2, 3), 16'h0001);
      chk_rd("ch2_wrap", a(2, 0), 16'h0000);
      step(1);
      chk("ch2_irq", {15'b0, irq}, 16'h0001);
      wr(a(2, 2), 16'h0004);
      wr(a(2, 3), 16'h0001);
      chk("ch2_irq_hold", {15'b0, irq}, 16'h0001);
      step(1);
      chk("ch2_irq_drop", {15'b0, irq}, 16'h0000);

      // Ch3: COUNT write beats a tick; EN cleared still takes that tick.
      wr(a(3, 2), 16'h0001);
      wr(a(3, 0), 16'h1234);
      chk_rd("ch3_write_wins", a(3, 0), 16'h1234);
      step(1);
      chk_rd("ch3_inc", a(3, 0), 16'h1235);
      wr(a(3, 2), 16'h0000);
      chk_rd("ch3_last_tick", a(3, 0), 16'h1236);
      step(1);
      chk_rd("ch3_stopped", a(3, 0), 16'h1236);

      // Ch3: RELOAD write during overflow loads the old RELOAD.
      wr(a(3, 1), 16'h0100);
      wr(a(3, 0), 16'hFFFF);
      wr(a(3, 2), 16'h0003);
      wr(a(3, 1), 16'h0200);
      chk_rd("ch3_old_reload", a(3, 0), 16'h0100);
      chk_rd("ch3_new_reload", a(3, 1), 16'h0200);
      wr(a(3, 2), 16'h0000);
      wr(a(3, 3), 16'h0001);
      chk_rd("ch3_status_clr", a(3, 3), 16'h0000);

      // CTRL readback masking, out-of-range channel, deselected read.
      wr(a(1, 2), 16'hFFFE);
      chk_rd("ctrl_mask", a(1, 2), 16'h00F6);
      wr(a(1, 2), 16'h0000);
      wr(a(1, 0), 16'h0055);
      wr(a(5, 0), 16'hBEEF);
      wr(a(5, 1), 16'h1111);
      wr(a(5, 2), 16'h0007);
      chk_rd("ch5_count", a(5, 0), 16'h0000);
      chk_rd("ch5_ctrl", a(5, 2), 16'h0000);
      chk_rd("ch1_no_alias_count", a(1, 0), 16'h0055);
      chk_rd("ch1_no_alias_reload", a(1, 1), 16'h0000);
      chk_rd("ch1_no_alias_ctrl", a(1, 2), 16'h0000);
      chk_rd("desel_read", 16'h0000, 16'h0000);

      // Two channels pending with IE; clear them one at a time.
      wr(a(0, 0), 16'hFFFF);
      wr(a(0, 2), 16'h0005);
      wr(a(0, 2), 16'h0004);
      wr(a(2, 0), 16'hFFFF);
      wr(a(2, 2), 16'h0005);
      wr(a(2, 2), 16'h0004);
      step(1);
      chk("two_irq", {15'b0, irq}, 16'h0001);
      chk("two_irq_vec", {12'b0, irq_vec}, 16'h0005);
      wr(a(0, 3), 16'h0000);
      chk_rd("status_w0_noop", a(0, 3), 16'h0001);
      wr(a(0, 3), 16'h0001);
      step(1);
      chk("one_irq", {15'b0, irq}, 16'h0001);
      chk("one_irq_vec", {12'b0, irq_vec}, 16'h0004);
      wr(a(2, 3), 16'h0001);
      step(1);
      chk("none_irq", {15'b0, irq}, 16'h0000);
      chk("none_irq_vec", {12'b0, irq_vec}, 16'h0000);

      // Asynchronous reset mid-count with irq asserted.
      wr(a(0, 0), 16'hFFFE);
      wr(a(0, 2), 16'h0005);
      step(3);
      chk("pre_rst_irq", {15'b0, irq}, 16'h0001);
      resetq = 1'b0;
      #1;
      chk("async_rst_irq", {15'b0, irq}, 16'h0000);
      chk("async_rst_vec", {12'b0, irq_vec}, 16'h0000);
      chk_rd("async_rst_count", a(0, 0), 16'h0000);
      chk_rd("async_rst_ctrl", a(0, 2), 16'h0000);
      chk_rd("async_rst_status", a(0, 3), 16'h0000);
      @(negedge clk) resetq = 1'b1;
      step(2);
      chk_rd("post_rst_idle", a(0, 0), 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
